lut_decode: RTL and testbench

LUT_DECODE -- requirements
Module: lut_decode

---
 rtl/lut_decode.sv | 152 +++++++++++++++
 tb/tb_lut_decode.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_decode.sv
// LUT coordinate decoder: turns Q11.5 source-coordinate words into integer/fraction
// coordinates through a small FIFO. Define LUT_FRAC_EN to keep fractions instead of rounding.
module lut_decode #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ltdata,
    input  logic        ltvalid,
    input  logic        ltlast,
    output logic        ltready,
    output logic [10:0] cd_x,
    output logic [10:0] cd_y,
    output logic [4:0]  cd_fx,
    output logic [4:0]  cd_fy,
    output logic        cd_oob,
    output logic        cdvalid,
    output logic        cdlast,
    input  logic        cdready,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [4:0]  fx;
        logic [4:0]  fy;
        logic        oob;
        logic        last;
    } entry_t;

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [18:0] LAST_PIX = 19'(IMG_W * IMG_H - 1);
`ifdef LUT_FRAC_EN
    // Bilinear needs the right/lower neighbour as well, hence the -2 limits.
    localparam logic [10:0] X_LIM = 11'(IMG_W - 2);
    localparam logic [10:0] Y_LIM = 11'(IMG_H - 2);
`else
    localparam logic [10:0] X_LIM = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LIM = 11'(IMG_H - 1);
`endif

    state_t        state, next_state;
    entry_t        mem [FIFO_DEPTH];
    entry_t        dec;
    entry_t        head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [18:0]   pix_cnt;
    logic          push, pop, full, empty, at_last_pix, term;

    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign ltready     = (state == RUN) && !full;
    assign cdvalid     = !empty;
    assign push        = ltvalid && ltready;
    assign pop         = cdvalid && cdready;
    assign at_last_pix = (pix_cnt == LAST_PIX);
    assign term        = ltlast || at_last_pix;
    assign busy        = (state != IDLE);
    assign done        = (state == DRAIN) && empty;

`ifdef LUT_FRAC_EN
    always_comb begin
        dec      = '0;
        dec.x    = ltdata[31:21];
        dec.fx   = ltdata[20:16];
        dec.y    = ltdata[15:5];
        dec.fy   = ltdata[4:0];
        dec.oob  = (dec.x > X_LIM) || (dec.y > Y_LIM);
        dec.last = term;
    end
`else
    logic [11:0] x_sum, y_sum;
    logic        unused_frac;

    assign unused_frac = &{1'b0, ltdata[19:16], ltdata[3:0]};
    assign x_sum       = {1'b0, ltdata[31:21]} + 12'(ltdata[20]);
    assign y_sum       = {1'b0, ltdata[15:5]} + 12'(ltdata[4]);

    // Round half-up; a carry out of bit 10 saturates to the largest coordinate.
    always_comb begin
        dec      = '0;
        dec.x    = x_sum[11] ? 11'h7FF : x_sum[10:0];
        dec.y    = y_sum[11] ? 11'h7FF : y_sum[10:0];
        dec.oob  = (dec.x > X_LIM) || (dec.y > Y_LIM);
        dec.last = term;
    end
`endif

    assign head   = mem[rptr];
    assign cd_x   = head.x;
    assign cd_y   = head.y;
    assign cd_fx  = head.fx;
    assign cd_fy  = head.fy;
    assign cd_oob = head.oob;
    assign cdlast = head.last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (push && term) next_state = DRAIN;
            DRAIN:   if (empty) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Storage is cleared on reset so the cd_* outputs read zero until refilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            pix_cnt <= '0;
            len_err <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= dec;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (state == IDLE && start) begin
                pix_cnt <= '0;
                len_err <= 1'b0;
            end else if (push) begin
                pix_cnt <= pix_cnt + 1'b1;
                if (term && (ltlast != at_last_pix)) len_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lut_decode.sv
// Self-checking bench for lut_decode: vector table plus scoreboard-driven frame sequences.
// Expectations follow LUT_FRAC_EN when it is defined for the compile.
module tb_lut_decode;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int DEPTH = 4;

    logic        clk, rst, start, ltvalid, ltlast, ltready, cdready;
    logic [31:0] ltdata;
    logic [10:0] cd_x, cd_y;
    logic [4:0]  cd_fx, cd_fy;
    logic        cd_oob, cdvalid, cdlast, busy, done, len_err;

    lut_decode #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ltdata(ltdata), .ltvalid(ltvalid), .ltlast(ltlast), .ltready(ltready),
        .cd_x(cd_x), .cd_y(cd_y), .cd_fx(cd_fx), .cd_fy(cd_fy), .cd_oob(cd_oob),
        .cdvalid(cdvalid), .cdlast(cdlast), .cdready(cdready),
        .busy(busy), .done(done), .len_err(len_err)
    );

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [4:0]  fx;
        logic [4:0]  fy;
        logic        oob;
        logic        last;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        ltl;
        exp_t        e;
    } vec_t;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     done_cnt = 0;
    bit     lat_chk = 0;
    exp_t   sb[$];
    exp_t   mon_e;
    vec_t   tbl[8];
    logic [31:0] words[8];
    exp_t   first_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endfunction

    function automatic exp_t mk(int x, int y, int fx, int fy, bit oob, bit last);
        exp_t e;
        e.x = 11'(x); e.y = 11'(y); e.fx = 5'(fx); e.fy = 5'(fy);
        e.oob = oob; e.last = last; e.cyc = 0;
        return e;
    endfunction

`ifdef LUT_FRAC_EN
    function automatic exp_t model(logic [31:0] d, logic last);
        exp_t e;
        e.x = d[31:21]; e.fx = d[20:16];
        e.y = d[15:5];  e.fy = d[4:0];
        e.oob = (int'(e.x) > IMG_W - 2) || (int'(e.y) > IMG_H - 2);
        e.last = last; e.cyc = 0;
        return e;
    endfunction
`else
    function automatic exp_t model(logic [31:0] d, logic last);
        exp_t e;
        int rx, ry;
        rx = int'(d[31:21]) + int'(d[20]);
        ry = int'(d[15:5]) + int'(d[4]);
        if (rx > 2047) rx = 2047;
        if (ry > 2047) ry = 2047;
        e.x = 11'(rx); e.y = 11'(ry); e.fx = '0; e.fy = '0;
        e.oob = (rx > IMG_W - 1) || (ry > IMG_H - 1);
        e.last = last; e.cyc = 0;
        return e;
    endfunction
`endif

    // Output side of the scoreboard: every accepted coordinate must match the oldest expectation.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && cdvalid && cdready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 32'(cd_x), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("cd_x", 32'(cd_x), 32'(mon_e.x));
                checkOutput("cd_y", 32'(cd_y), 32'(mon_e.y));
                checkOutput("cd_fx", 32'(cd_fx), 32'(mon_e.fx));
                checkOutput("cd_fy", 32'(cd_fy), 32'(mon_e.fy));
                checkOutput("cd_oob", 32'(cd_oob), 32'(mon_e.oob));
                checkOutput("cdlast", 32'(cdlast), 32'(mon_e.last));
                if (lat_chk) checkOutput("latency", cyc, mon_e.cyc + 1);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input logic l, input exp_t e);
        exp_t t;
        bit   ok = 0;
        t = e;
        ltdata = d; ltlast = l; ltvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ltready) begin
                t.cyc = cyc;
                sb.push_back(t);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("handshake_timeout", 32'd0, 32'd1);
            ltvalid = 1'b0; ltlast = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        ltvalid = 1'b0; ltlast = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input int d0, input logic exp_err);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        checkOutput("frame_end", 32'(ok), 32'd1);
        checkOutput("done_pulses", 32'(done_cnt - d0), 32'd1);
        checkOutput("len_err", 32'(len_err), 32'(exp_err));
        checkOutput("idle_ltready", 32'(ltready), 32'd0);
        checkOutput("idle_cdvalid", 32'(cdvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        logic [31:0] d;

`ifdef LUT_FRAC_EN
        tbl[0] = '{data: 32'h0000_0000, ltl: 1'b0, e: mk(0,    0,    0,  0,  1'b0, 1'b0)};
        tbl[1] = '{data: 32'h0023_0041, ltl: 1'b0, e: mk(1,    2,    3,  1,  1'b1, 1'b0)};
        tbl[2] = '{data: 32'h0050_000F, ltl: 1'b0, e: mk(2,    0,    16, 15, 1'b0, 1'b0)};
        tbl[3] = '{data: 32'h007F_0030, ltl: 1'b0, e: mk(3,    1,    31, 16, 1'b1, 1'b0)};
        tbl[4] = '{data: 32'hFFF0_FFD0, ltl: 1'b0, e: mk(2047, 2046, 16, 16, 1'b1, 1'b0)};
        tbl[5] = '{data: 32'h002F_0020, ltl: 1'b0, e: mk(1,    1,    15, 0,  1'b1, 1'b0)};
        tbl[6] = '{data: 32'h0040_0010, ltl: 1'b0, e: mk(2,    0,    0,  16, 1'b0, 1'b0)};
        tbl[7] = '{data: 32'h0008_0000, ltl: 1'b1, e: mk(0,    0,    8,  0,  1'b0, 1'b1)};
`else
        tbl[0] = '{data: 32'h0000_0000, ltl: 1'b0, e: mk(0,    0,    0, 0, 1'b0, 1'b0)};
        tbl[1] = '{data: 32'h0023_0041, ltl: 1'b0, e: mk(1,    2,    0, 0, 1'b1, 1'b0)};
        tbl[2] = '{data: 32'h0050_000F, ltl: 1'b0, e: mk(3,    0,    0, 0, 1'b0, 1'b0)};
        tbl[3] = '{data: 32'h007F_0030, ltl: 1'b0, e: mk(4,    2,    0, 0, 1'b1, 1'b0)};
        tbl[4] = '{data: 32'hFFF0_FFD0, ltl: 1'b0, e: mk(2047, 2047, 0, 0, 1'b1, 1'b0)};
        tbl[5] = '{data: 32'h002F_0020, ltl: 1'b0, e: mk(1,    1,    0, 0, 1'b0, 1'b0)};
        tbl[6] = '{data: 32'h0040_0010, ltl: 1'b0, e: mk(2,    1,    0, 0, 1'b0, 1'b0)};
        tbl[7] = '{data: 32'h0008_0000, ltl: 1'b1, e: mk(0,    0,    0, 0, 1'b0, 1'b1)};
`endif

        rst = 1'b1; start = 1'b0; ltvalid = 1'b0; ltlast = 1'b0; ltdata = '0; cdready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ltready", 32'(ltready), 32'd0);
        checkOutput("rst_cdvalid", 32'(cdvalid), 32'd0);
        checkOutput("rst_cdlast", 32'(cdlast), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_len_err", 32'(len_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cd", 32'({cd_x, cd_y, cd_fx, cd_fy, cd_oob}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("no_start_ltready", 32'(ltready), 32'd0);

        // Frame 1: table vectors, ltlast agrees with the pixel count.
        $display("[TB] frame 1: vector table");
        lat_chk = 1;
        d0 = done_cnt;
        pulseStart();
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_ltready", 32'(ltready), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(tbl[i].data, tbl[i].ltl, tbl[i].e);
        waitIdle(d0, 1'b0);

        // Frame 2: ltlast arrives early on word 5.
        $display("[TB] frame 2: short frame");
        d0 = done_cnt;
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            d = $urandom();
            applyStimulus(d, i == 4, model(d, i == 4));
        end
        waitIdle(d0, 1'b1);
        ltvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("after_frame_ltready", 32'(ltready), 32'd0);
        end
        @(posedge clk); #1;
        ltvalid = 1'b0;

        // Frame 3: counter ends the frame without ltlast, which is a length error.
        $display("[TB] frame 3: counter-terminated frame");
        d0 = done_cnt;
        pulseStart();
        checkOutput("start_clears_len_err", 32'(len_err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            d = $urandom() & 32'h00FF_00FF;
            applyStimulus(d, 1'b0, model(d, i == 7));
        end
        waitIdle(d0, 1'b1);

        // Frame 4: downstream stalls until the FIFO fills.
        $display("[TB] frame 4: back-pressure");
        lat_chk = 0;
        cdready = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) words[i] = $urandom();
        first_e = model(words[0], 1'b0);
        pulseStart();
        for (int i = 0; i < DEPTH; i++) applyStimulus(words[i], 1'b0, model(words[i], 1'b0));
        ltdata = words[DEPTH]; ltvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("full_ltready", 32'(ltready), 32'd0);
            checkOutput("stall_cdvalid", 32'(cdvalid), 32'd1);
            checkOutput("stall_cd", 32'({cd_x, cd_y, cd_fx, cd_fy, cd_oob}),
                        32'({first_e.x, first_e.y, first_e.fx, first_e.fy, first_e.oob}));
        end
        @(posedge clk); #1;
        cdready = 1'b1;
        for (int i = DEPTH; i < 8; i++) applyStimulus(words[i], i == 7, model(words[i], i == 7));
        waitIdle(d0, 1'b0);

        // Frame 5: reset lands mid-frame with entries buffered.
        $display("[TB] frame 5: reset mid-frame");
        cdready = 1'b0;
        pulseStart();
        for (int i = 0; i < 3; i++) begin
            d = $urandom();
            applyStimulus(d, 1'b0, model(d, 1'b0));
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst_cdvalid", 32'(cdvalid), 32'd0);
        checkOutput("midrst_ltready", 32'(ltready), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_cd", 32'({cd_x, cd_y, cd_fx, cd_fy, cd_oob, cdlast}), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cdready = 1'b1;
        ltvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("postrst_ltready", 32'(ltready), 32'd0);
            checkOutput("postrst_cdvalid", 32'(cdvalid), 32'd0);
        end
        @(posedge clk); #1;
        ltvalid = 1'b0;
        lat_chk = 1;
        d0 = done_cnt;
        pulseStart();
        for (int i = 0; i < 8; i++) begin
            d = $urandom();
            applyStimulus(d, i == 7, model(d, i == 7));
        end
        waitIdle(d0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
